// File: rtl/qsfp_ctrl_pkg.sv
// Shared state encodings for the QSFP bring-up sequencer and its per-cage controllers.
package qsfp_ctrl_pkg;

    localparam logic [1:0] G_REFRST = 2'd0;
    localparam logic [1:0] G_SYSRST = 2'd1;
    localparam logic [1:0] G_RUN    = 2'd2;

    localparam logic [1:0] P_IDLE   = 2'd0;
    localparam logic [1:0] P_RESET  = 2'd1;
    localparam logic [1:0] P_INIT   = 2'd2;
    localparam logic [1:0] P_READY  = 2'd3;

endpackage

// File: rtl/qsfp_port_ctrl.sv
// One QSFP cage: presence synchroniser and debounce, module reset/init FSM and LPMODE gating.
module qsfp_port_ctrl
    import qsfp_ctrl_pkg::*;
#(
    parameter int CNT_W           = 16,
    parameter int MOD_RST_CYCLES  = 256,
    parameter int MOD_INIT_CYCLES = 4096,
    parameter int DEBOUNCE_CYCLES = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    input  logic i_modprsl,
    input  logic i_lpmode_req,
    output logic o_resetl,
    output logic o_lpmode,
    output logic o_present,
    output logic o_ready
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(MOD_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(MOD_INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             w_raw;
    logic [CNT_W-1:0] r_dcnt;
    logic             r_present;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic             w_resetl_next;
    logic             w_lpmode_next;
    logic             w_ready_next;
    logic             r_resetl;
    logic             r_lpmode;
    logic             r_ready;

    // Synchroniser resets to 1 so an empty cage is assumed until proven otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_modprsl};
        end
    end

    assign w_raw = ~r_sync[1];

    // Presence only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dcnt    <= CNT_ZERO;
            r_present <= 1'b0;
        end else if (w_raw != r_present) begin
            if (r_dcnt == DEB_LAST) begin
                r_dcnt    <= CNT_ZERO;
                r_present <= ~r_present;
            end else begin
                r_dcnt    <= r_dcnt + CNT_ONE;
            end
        end else begin
            r_dcnt <= CNT_ZERO;
        end
    end

    // Port FSM state, counter and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= P_IDLE;
            r_cnt    <= CNT_ZERO;
            r_resetl <= 1'b0;
            r_lpmode <= 1'b1;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_resetl <= w_resetl_next;
            r_lpmode <= w_lpmode_next;
            r_ready  <= w_ready_next;
        end
    end

    // Removal or loss of global run outranks every terminal count.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (!i_run || !r_present) begin
            w_state_next = P_IDLE;
            w_cnt_next   = CNT_ZERO;
        end else begin
            case (r_state)
                P_IDLE: begin
                    w_state_next = P_RESET;
                    w_cnt_next   = CNT_ZERO;
                end
                P_RESET: begin
                    if (r_cnt == RST_LAST) begin
                        w_state_next = P_INIT;
                        w_cnt_next   = CNT_ZERO;
                    end else begin
                        w_cnt_next   = r_cnt + CNT_ONE;
                    end
                end
                P_INIT: begin
                    if (r_cnt == INIT_LAST) begin
                        w_state_next = P_READY;
                        w_cnt_next   = CNT_ZERO;
                    end else begin
                        w_cnt_next   = r_cnt + CNT_ONE;
                    end
                end
                P_READY: begin
                    w_state_next = P_READY;
                    w_cnt_next   = CNT_ZERO;
                end
                default: begin
                    w_state_next = P_IDLE;
                    w_cnt_next   = CNT_ZERO;
                end
            endcase
        end
    end

    // Outputs decoded from the next state so they change on the same edge as the FSM.
    always_comb begin
        w_resetl_next = 1'b0;
        w_lpmode_next = 1'b1;
        w_ready_next  = 1'b0;
        case (w_state_next)
            P_IDLE, P_RESET: begin
                w_resetl_next = 1'b0;
            end
            P_INIT: begin
                w_resetl_next = 1'b1;
            end
            P_READY: begin
                w_resetl_next = 1'b1;
                w_lpmode_next = i_lpmode_req;
                w_ready_next  = 1'b1;
            end
            default: begin
                w_resetl_next = 1'b0;
            end
        endcase
    end

    assign o_resetl  = r_resetl;
    assign o_lpmode  = r_lpmode;
    assign o_present = r_present;
    assign o_ready   = r_ready;

endmodule

// File: rtl/qsfp_reset_sequencer.sv
// Board bring-up: refclk generator reset, then MMCM/system reset, then per-cage module sequencing.
module qsfp_reset_sequencer
    import qsfp_ctrl_pkg::*;
#(
    parameter int QSFP_CNT          = 2,
    parameter int CNT_W             = 16,
    parameter int REFCLK_RST_CYCLES = 1024,
    parameter int SYS_RST_CYCLES    = 1024,
    parameter int MOD_RST_CYCLES    = 256,
    parameter int MOD_INIT_CYCLES   = 4096,
    parameter int DEBOUNCE_CYCLES   = 64
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req_reset,
    output logic                o_refclk_reset,
    output logic                o_sys_rst,
    output logic                o_sys_ready,
    input  logic [QSFP_CNT-1:0] i_qsfp_modprsl,
    input  logic [QSFP_CNT-1:0] i_qsfp_lpmode_req,
    output logic [QSFP_CNT-1:0] o_qsfp_resetl,
    output logic [QSFP_CNT-1:0] o_qsfp_lpmode,
    output logic [QSFP_CNT-1:0] o_qsfp_present,
    output logic [QSFP_CNT-1:0] o_qsfp_ready
);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFCLK_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SYS_LAST = CNT_W'(SYS_RST_CYCLES - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic             w_refclk_reset_next;
    logic             w_sys_rst_next;
    logic             w_sys_ready_next;
    logic             r_refclk_reset;
    logic             r_sys_rst;
    logic             r_sys_ready;
    logic             w_run;

    // Global FSM state, shared counter and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= G_REFRST;
            r_cnt          <= CNT_ZERO;
            r_refclk_reset <= 1'b1;
            r_sys_rst      <= 1'b1;
            r_sys_ready    <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_refclk_reset <= w_refclk_reset_next;
            r_sys_rst      <= w_sys_rst_next;
            r_sys_ready    <= w_sys_ready_next;
        end
    end

    // A restart request outranks the terminal counts and pins the counter at zero.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (i_req_reset) begin
            w_state_next = G_REFRST;
            w_cnt_next   = CNT_ZERO;
        end else begin
            case (r_state)
                G_REFRST: begin
                    if (r_cnt == REF_LAST) begin
                        w_state_next = G_SYSRST;
                        w_cnt_next   = CNT_ZERO;
                    end else begin
                        w_cnt_next   = r_cnt + CNT_ONE;
                    end
                end
                G_SYSRST: begin
                    if (r_cnt == SYS_LAST) begin
                        w_state_next = G_RUN;
                        w_cnt_next   = CNT_ZERO;
                    end else begin
                        w_cnt_next   = r_cnt + CNT_ONE;
                    end
                end
                G_RUN: begin
                    w_state_next = G_RUN;
                    w_cnt_next   = CNT_ZERO;
                end
                default: begin
                    w_state_next = G_REFRST;
                    w_cnt_next   = CNT_ZERO;
                end
            endcase
        end
    end

    // Global outputs follow the next state.
    always_comb begin
        w_refclk_reset_next = 1'b1;
        w_sys_rst_next      = 1'b1;
        w_sys_ready_next    = 1'b0;
        case (w_state_next)
            G_REFRST: begin
                w_refclk_reset_next = 1'b1;
            end
            G_SYSRST: begin
                w_refclk_reset_next = 1'b0;
            end
            G_RUN: begin
                w_refclk_reset_next = 1'b0;
                w_sys_rst_next      = 1'b0;
                w_sys_ready_next    = 1'b1;
            end
            default: begin
                w_refclk_reset_next = 1'b1;
            end
        endcase
    end

    // Dropping run on the request edge lets ports leave P_IDLE-bound on that same edge.
    assign w_run = (r_state == G_RUN) && !i_req_reset;

    for (genvar g = 0; g < QSFP_CNT; g++) begin : g_port
        qsfp_port_ctrl #(
            .CNT_W           (CNT_W),
            .MOD_RST_CYCLES  (MOD_RST_CYCLES),
            .MOD_INIT_CYCLES (MOD_INIT_CYCLES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_port (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_run        (w_run),
            .i_modprsl    (i_qsfp_modprsl[g]),
            .i_lpmode_req (i_qsfp_lpmode_req[g]),
            .o_resetl     (o_qsfp_resetl[g]),
            .o_lpmode     (o_qsfp_lpmode[g]),
            .o_present    (o_qsfp_present[g]),
            .o_ready      (o_qsfp_ready[g])
        );
    end

    assign o_refclk_reset = r_refclk_reset;
    assign o_sys_rst      = r_sys_rst;
    assign o_sys_ready    = r_sys_ready;

endmodule

// File: tb/tb_qsfp_reset_sequencer.sv
// Directed bench for qsfp_reset_sequencer with short timings; expectations are edge numbers since rst release.
module tb_qsfp_reset_sequencer;

    logic       clk;
    logic       rst;
    logic       req_reset;
    logic       refclk_reset;
    logic       sys_rst;
    logic       sys_ready;
    logic [1:0] modprsl;
    logic [1:0] lpmode_req;
    logic [1:0] resetl;
    logic [1:0] lpmode;
    logic [1:0] present;
    logic [1:0] ready;

    int n_checks;
    int n_errors;
    int n;

    qsfp_reset_sequencer #(
        .QSFP_CNT          (2),
        .CNT_W             (16),
        .REFCLK_RST_CYCLES (8),
        .SYS_RST_CYCLES    (8),
        .MOD_RST_CYCLES    (4),
        .MOD_INIT_CYCLES   (6),
        .DEBOUNCE_CYCLES   (3)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_req_reset       (req_reset),
        .o_refclk_reset    (refclk_reset),
        .o_sys_rst         (sys_rst),
        .o_sys_ready       (sys_ready),
        .i_qsfp_modprsl    (modprsl),
        .i_qsfp_lpmode_req (lpmode_req),
        .o_qsfp_resetl     (resetl),
        .o_qsfp_lpmode     (lpmode),
        .o_qsfp_present    (present),
        .o_qsfp_ready      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n = n + 1;
    endtask

    task automatic step_to(input int target);
        while (n < target) step();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_refclk"}, 32'(refclk_reset), 32'd1);
        check({tag, "_sysrst"}, 32'(sys_rst), 32'd1);
        check({tag, "_sysrdy"}, 32'(sys_ready), 32'd0);
        check({tag, "_resetl"}, 32'(resetl), 32'd0);
        check({tag, "_lpmode"}, 32'(lpmode), 32'd3);
        check({tag, "_present"}, 32'(present), 32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        n          = 0;
        rst        = 1'b1;
        req_reset  = 1'b0;
        modprsl    = 2'b10;
        lpmode_req = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");

        // Boot with cage0 present: global sequence then cage0 port sequence.
        rst = 1'b0;
        n   = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            check("boot_refclk", 32'(refclk_reset), (n < 8) ? 32'd1 : 32'd0);
            check("boot_sysrst", 32'(sys_rst), (n < 16) ? 32'd1 : 32'd0);
            check("boot_sysrdy", 32'(sys_ready), (n >= 16) ? 32'd1 : 32'd0);
            check("boot_present", 32'(present), (n >= 5) ? 32'd1 : 32'd0);
            check("boot_resetl", 32'(resetl), (n >= 21) ? 32'd1 : 32'd0);
            check("boot_ready", 32'(ready), (n >= 27) ? 32'd1 : 32'd0);
            check("boot_lpmode", 32'(lpmode), (n >= 27) ? 32'd2 : 32'd3);
        end

        // Two-sample glitch on cage0 is rejected.
        modprsl = 2'b11;
        step_to(32);
        modprsl = 2'b10;
        for (int k = 33; k <= 40; k++) begin
            step();
            check("glitch2_present", 32'(present), 32'd1);
            check("glitch2_ready", 32'(ready), 32'd1);
        end

        // Three-sample pulse removes cage0, then re-insertion reruns its sequence.
        modprsl = 2'b11;
        step_to(43);
        modprsl = 2'b10;
        step_to(44);
        check("rm_present_44", 32'(present), 32'd1);
        step_to(45);
        check("rm_present_45", 32'(present), 32'd0);
        check("rm_ready_45", 32'(ready), 32'd1);
        step_to(46);
        check("rm_resetl_46", 32'(resetl), 32'd0);
        check("rm_ready_46", 32'(ready), 32'd0);
        check("rm_lpmode_46", 32'(lpmode), 32'd3);
        step_to(47);
        check("rm_present_47", 32'(present), 32'd0);
        step_to(48);
        check("ins_present_48", 32'(present), 32'd1);
        step_to(52);
        check("ins_resetl_52", 32'(resetl), 32'd0);
        step_to(53);
        check("ins_resetl_53", 32'(resetl), 32'd1);
        step_to(58);
        check("ins_ready_58", 32'(ready), 32'd0);
        check("ins_lpmode_58", 32'(lpmode), 32'd3);
        step_to(59);
        check("ins_ready_59", 32'(ready), 32'd1);
        check("ins_lpmode_59", 32'(lpmode), 32'd2);

        // Cage1 insertion while cage0 stays ready.
        step_to(60);
        modprsl = 2'b00;
        step_to(64);
        check("c1_present_64", 32'(present), 32'd1);
        step_to(65);
        check("c1_present_65", 32'(present), 32'd3);
        step_to(69);
        check("c1_resetl_69", 32'(resetl), 32'd1);
        step_to(70);
        check("c1_resetl_70", 32'(resetl), 32'd3);
        step_to(75);
        check("c1_ready_75", 32'(ready), 32'd1);
        check("c1_lpmode_75", 32'(lpmode), 32'd2);
        step_to(76);
        check("c1_ready_76", 32'(ready), 32'd3);
        check("c1_lpmode_76", 32'(lpmode), 32'd0);

        // LPMODE follows the request once ready.
        step_to(77);
        lpmode_req = 2'b01;
        step_to(78);
        check("lpreq_lpmode_78", 32'(lpmode), 32'd1);

        // One-cycle restart request with both cages ready.
        step_to(80);
        req_reset = 1'b1;
        step_to(81);
        req_reset = 1'b0;
        check("req_refclk_81", 32'(refclk_reset), 32'd1);
        check("req_sysrst_81", 32'(sys_rst), 32'd1);
        check("req_sysrdy_81", 32'(sys_ready), 32'd0);
        check("req_ready_81", 32'(ready), 32'd0);
        check("req_resetl_81", 32'(resetl), 32'd0);
        check("req_lpmode_81", 32'(lpmode), 32'd3);
        step_to(88);
        check("req_refclk_88", 32'(refclk_reset), 32'd1);
        step_to(89);
        check("req_refclk_89", 32'(refclk_reset), 32'd0);
        check("req_sysrst_89", 32'(sys_rst), 32'd1);
        step_to(96);
        check("req_sysrdy_96", 32'(sys_ready), 32'd0);
        step_to(97);
        check("req_sysrdy_97", 32'(sys_ready), 32'd1);
        check("req_sysrst_97", 32'(sys_rst), 32'd0);
        step_to(101);
        check("req_resetl_101", 32'(resetl), 32'd0);
        step_to(102);
        check("req_resetl_102", 32'(resetl), 32'd3);
        check("req_ready_102", 32'(ready), 32'd0);

        // Asynchronous reset in P_INIT: outputs drop back without a clock edge.
        step_to(105);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("arst");

        // Reboot with both cages present; a held request coincides with the P_INIT terminal count.
        modprsl = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n   = 0;
        step_to(26);
        check("rb_resetl_26", 32'(resetl), 32'd3);
        check("rb_ready_26", 32'(ready), 32'd0);
        req_reset = 1'b1;
        step_to(27);
        check("tc_ready_27", 32'(ready), 32'd0);
        check("tc_resetl_27", 32'(resetl), 32'd0);
        check("tc_refclk_27", 32'(refclk_reset), 32'd1);
        check("tc_sysrdy_27", 32'(sys_ready), 32'd0);
        check("tc_lpmode_27", 32'(lpmode), 32'd3);
        step_to(29);
        req_reset = 1'b0;
        check("hold_refclk_29", 32'(refclk_reset), 32'd1);
        step_to(36);
        check("hold_refclk_36", 32'(refclk_reset), 32'd1);
        step_to(37);
        check("hold_refclk_37", 32'(refclk_reset), 32'd0);
        check("hold_present_37", 32'(present), 32'd3);
        step_to(44);
        check("hold_sysrdy_44", 32'(sys_ready), 32'd0);
        step_to(45);
        check("hold_sysrdy_45", 32'(sys_ready), 32'd1);
        step_to(55);
        check("hold_ready_55", 32'(ready), 32'd0);
        step_to(56);
        check("hold_ready_56", 32'(ready), 32'd3);
        check("hold_lpmode_56", 32'(lpmode), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
